// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port backing memory between the I-cache refill path and
// the D-cache refill/writeback path. One line transfer is granted at a time.
// Ties go round-robin. The FSM walks the beat addresses of the line and
// routes data, valid and done back to whichever requester owns the burst.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   ic_req/ic_addr        I-cache line refill request and address
//   ic_rdata/valid/done   I-cache refill beat data, beat strobe, last-beat pulse
//   dc_req/dc_we/dc_addr  D-cache request (we=1 writeback, 0 refill), address
//   dc_wdata              writeback word for the current beat_idx
//   dc_rdata/valid/done   D-cache refill data, beat strobe, last-beat pulse
//   beat_idx              beat number within the active burst
//   mem_*                 single-beat memory port (req/we/addr/wdata/rdata/ready)
//   stall_fetch/stall_mem pipeline freeze while a request is outstanding
module mem_port_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ic_req,
  input  logic [ADDR_W-1:0]             ic_addr,
  output logic [31:0]                   ic_rdata,
  output logic                          ic_valid,
  output logic                          ic_done,
  input  logic                          dc_req,
  input  logic                          dc_we,
  input  logic [ADDR_W-1:0]             dc_addr,
  input  logic [31:0]                   dc_wdata,
  output logic [31:0]                   dc_rdata,
  output logic                          dc_valid,
  output logic                          dc_done,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  input  logic                          mem_ready,
  output logic                          stall_fetch,
  output logic                          stall_mem
);

  localparam int BW = $clog2(LINE_WORDS);
  // Byte-offset bits within a line; masking (rather than slicing) keeps every
  // address bit in use.
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, IC_RD, DC_RD, DC_WR} state_t;
  typedef enum logic {GNT_IC, GNT_DC} grant_t;

  state_t            state;
  grant_t            last_grant;
  logic [ADDR_W-1:0] base_addr;
  logic              in_burst;
  logic              last_beat;
  logic              ic_pick;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  assign in_burst  = (state != IDLE);
  assign last_beat = (beat_idx == LAST_BEAT);
  // IC wins when it is alone, or on a tie when DC had the previous grant.
  assign ic_pick   = ic_req && (!dc_req || last_grant == GNT_DC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_idx   <= '0;
      base_addr  <= '0;
      last_grant <= GNT_IC;
    end else begin
      case (state)
        IDLE: begin
          if (ic_pick) begin
            state      <= IC_RD;
            last_grant <= GNT_IC;
            base_addr  <= line_base(ic_addr);
            beat_idx   <= '0;
          end else if (dc_req) begin
            state      <= dc_we ? DC_WR : DC_RD;
            last_grant <= GNT_DC;
            base_addr  <= line_base(dc_addr);
            beat_idx   <= '0;
          end
        end
        default: begin
          // Requests are not re-examined mid-burst; the line always completes.
          if (mem_ready) begin
            if (last_beat) begin
              state    <= IDLE;
              beat_idx <= '0;
            end else begin
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end
      endcase
    end
  end

  // Memory side. The base is line-aligned so the beat offset never carries.
  assign mem_req   = in_burst;
  assign mem_we    = (state == DC_WR);
  assign mem_addr  = base_addr + ADDR_W'({beat_idx, 2'b00});
  assign mem_wdata = mem_we ? dc_wdata : 32'd0;

  // Requester side
  assign ic_rdata    = mem_rdata;
  assign dc_rdata    = mem_rdata;
  assign ic_valid    = (state == IC_RD) && mem_ready;
  assign ic_done     = ic_valid && last_beat;
  assign dc_valid    = ((state == DC_RD) || (state == DC_WR)) && mem_ready;
  assign dc_done     = dc_valid && last_beat;
  assign stall_fetch = ic_req && !ic_done;
  assign stall_mem   = dc_req && !dc_done;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and burst sequencer that shares one single-port backing memory between the instruction-cache refill path (fetch side) and the data-cache refill/writeback path (memory stage). It grants one line transfer at a time, walks the beat addresses, and routes data and acknowledges back. It drives `stall_fetch` and `stall_mem` so the hazard logic can freeze the pipeline while a transfer is outstanding.

## Interface
- `LINE_WORDS`, default 4: 32-bit words per cache line; power of two, at least 2.
- `ADDR_W`, default 32: byte-address width.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ic_req` in 1: I-cache line refill request; held until `ic_done`.
- `ic_addr` in ADDR_W: any byte address within the requested line.
- `ic_rdata` out 32: refill word, equal to `mem_rdata`.
- `ic_valid` out 1: `ic_rdata` is valid this cycle for beat `beat_idx`.
- `ic_done` out 1: one-cycle pulse coincident with the final `ic_valid`.
- `dc_req` in 1: D-cache transfer request; held until `dc_done`.
- `dc_we` in 1: 1 means line writeback, 0 means line refill; sampled at grant.
- `dc_addr` in ADDR_W: any byte address within the line.
- `dc_wdata` in 32: writeback word for the current `beat_idx`; driven combinationally by the D-cache.
- `dc_rdata` out 32: refill word, equal to `mem_rdata`.
- `dc_valid` out 1: beat accepted. For reads, `dc_rdata` is valid; for writes, `dc_wdata` was consumed.
- `dc_done` out 1: one-cycle pulse coincident with the final `dc_valid`.
- `beat_idx` out $clog2(LINE_WORDS): current beat number within the active burst.
- `mem_req` out 1: memory transfer request, one beat at a time.
- `mem_we` out 1: write strobe for the current beat.
- `mem_addr` out ADDR_W: word address of the current beat.
- `mem_wdata` out 32: equal to `dc_wdata` during a writeback, 0 otherwise.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.
- `mem_ready` in 1: beat completes on a cycle where `mem_req && mem_ready`.
- `stall_fetch` out 1: `ic_req && !ic_done`.
- `stall_mem` out 1: `dc_req && !dc_done`.

## Operation
- FSM states: IDLE, IC_RD, DC_RD, DC_WR. Registers are `state`, `beat_idx`, `base_addr`, and `last_grant` (IC or DC).
- In IDLE:
  - Only `ic_req` high: go to IC_RD.
  - Only `dc_req` high: go to DC_RD if `dc_we` is 0, DC_WR if `dc_we` is 1.
  - Both high: grant the requester that was not granted last (round-robin). Update `last_grant` at the grant.
  - At the grant, latch `base_addr` = requester address with the low $clog2(LINE_WORDS)+2 bits cleared, and set `beat_idx` to 0.
- In a burst state:
  - `mem_req` = 1.
  - `mem_addr` = `base_addr` + 4·`beat_idx`. The add is ADDR_W bits wide and never carries out of the line because the base is aligned.
  - `mem_we` = 1 only in DC_WR.
- Beat accept is `mem_ready` high in a burst state. On accept:
  - Assert the owner's `*_valid`.
  - If not the last beat, increment `beat_idx`.
  - If `beat_idx` == LINE_WORDS−1, assert the owner's `*_done`, return to IDLE, and clear `beat_idx` to 0.
- `mem_ready` low: hold state, `beat_idx`, and `mem_addr`; no valid pulse.
- A requester dropping `*_req` mid-burst is ignored. The burst completes and `*_done` still pulses.
- `mem_req`, `mem_we`, `*_valid`, `*_done`, and `mem_wdata` are combinational from state and `mem_ready`. `mem_addr` and `beat_idx` are registered-derived.
- `ic_valid`/`ic_done` are never asserted outside IC_RD. `dc_valid`/`dc_done` are never asserted outside DC_RD or DC_WR.
- Reset (asynchronous, mid-burst included):
  - `state` = IDLE, `beat_idx` = 0, `base_addr` = 0, `last_grant` = IC, so DC wins the first tie.
  - `mem_req` and `mem_we` fall immediately without waiting for a clock.
  - A partial burst is abandoned. Requesters must re-request after `rst_n` rises.

## Timing
- Reset values of all outputs: `mem_req`, `mem_we`, `ic_valid`, `ic_done`, `dc_valid`, `dc_done`, `beat_idx`, and `mem_wdata` are 0; `mem_addr` is 0.
- `stall_*` during reset follow their request inputs.
- Grant latency: request seen in IDLE at edge N, so `mem_req` is high in cycle N+1.
- Minimum burst is LINE_WORDS cycles, with `mem_ready` tied high.
- Back-to-back transfers: the FSM is in IDLE for one cycle after `*_done`. The next grant is taken at that cycle's edge, so there is exactly one idle cycle between bursts.
- Total service time with `mem_ready` high: 1 grant cycle + LINE_WORDS beat cycles.
- `stall_*` falls in the cycle `*_done` pulses, provided the requester deasserts `*_req` at the following edge.

## Test plan
- **Reset.** Hold `rst_n` low with `ic_req` = `dc_req` = 1 → `mem_req` = 0, `beat_idx` = 0, and all valid/done outputs = 0; `stall_fetch` = `stall_mem` = 1.
- **IC refill.** LINE_WORDS = 4, `ic_addr` = 0x0000_1234, `mem_ready` = 1 → `mem_addr` = 0x1230, 0x1234, 0x1238, 0x123C on cycles 1–4; `ic_valid` high on cycles 1–4; `ic_done` on cycle 4 only; `stall_fetch` = 0 after `ic_req` drops.
- **Tie after reset.** Both requests at cycle 0 → DC_RD granted first (4 beats, cycles 1–4); IDLE on cycle 5; IC_RD beats on cycles 6–9.
- **Writeback with stalls.** `dc_we` = 1, `dc_addr` = 0x8000_0040, `mem_ready` pattern 1,0,0,1,1,0,1 → `mem_we` = 1 throughout; `mem_addr` holds 0x8000_0044 across the two low cycles; `mem_wdata` tracks `dc_wdata` indexed by `beat_idx`; `dc_done` on the 7th cycle.
- **Reset mid-burst.** Assert `rst_n` low during beat 2 of an IC refill → `mem_req` falls asynchronously and no `ic_done` is produced. After release, the re-request restarts at `mem_addr` = base, `beat_idx` = 0.
- **Fairness.** `ic_req` and `dc_req` held high continuously, re-asserted after each done → grants alternate DC, IC, DC, IC; neither requester is granted twice in a row.
